// File: rtl/rr_mux_pkg.sv
// Shared definitions for the two-source round-robin stream arbiter:
// FSM state encoding and source identifiers.
package rr_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Lock state that corresponds to holding the link for a given source.
  function automatic state_t lock_state(input logic src);
    lock_state = (src == SRC_B) ? ST_LOCK_B : ST_LOCK_A;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Combinational grant selection: a locked source keeps the link, otherwise
// a lone valid source wins and a contested IDLE cycle goes to prio.
module rr_grant2
  import rr_mux_pkg::*;
(
  input  state_t state,
  input  logic   prio,
  input  logic   a_valid,
  input  logic   b_valid,
  output logic   grant_vld,
  output logic   grant_src
);

  // Grant decision by FSM state
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_A;
    case (state)
      ST_IDLE: begin
        if (a_valid && b_valid) begin
          grant_vld = 1'b1;
          grant_src = prio;
        end else if (a_valid) begin
          grant_vld = 1'b1;
          grant_src = SRC_A;
        end else if (b_valid) begin
          grant_vld = 1'b1;
          grant_src = SRC_B;
        end else begin
          grant_vld = 1'b0;
          grant_src = SRC_A;
        end
      end
      ST_LOCK_A: begin
        grant_vld = 1'b1;
        grant_src = SRC_A;
      end
      ST_LOCK_B: begin
        grant_vld = 1'b1;
        grant_src = SRC_B;
      end
      default: begin
        grant_vld = 1'b0;
        grant_src = SRC_A;
      end
    endcase
  end

endmodule

// File: rtl/rr_stream_mux2.sv
// Two-source round-robin packet arbiter with a registered output stage and
// a lock watchdog that releases a packet whose source stops delivering beats.
module rr_stream_mux2
  import rr_mux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  output logic             err_timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_sel_q, out_sel_d;
  logic             err_q, err_d;

  logic grant_vld_s, grant_src_s;
  logic can_acc_s, acc_s, acc_last_s;

  rr_grant2 u_grant (
    .state     (state_q),
    .prio      (prio_q),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .grant_vld (grant_vld_s),
    .grant_src (grant_src_s)
  );

  // Handshake: nothing is accepted while reset is asserted
  always_comb begin
    can_acc_s  = !rst && (!out_valid_q || out_ready);
    a_ready    = can_acc_s && grant_vld_s && (grant_src_s == SRC_A);
    b_ready    = can_acc_s && grant_vld_s && (grant_src_s == SRC_B);
    acc_s      = (a_valid && a_ready) || (b_valid && b_ready);
    acc_last_s = (grant_src_s == SRC_B) ? b_last : a_last;
  end

  // Next state: packet FSM, watchdog and output register
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (acc_s) begin
      cnt_d       = {CW{1'b0}};
      out_valid_d = 1'b1;
      out_data_d  = (grant_src_s == SRC_B) ? b_data : a_data;
      out_last_d  = acc_last_s;
      out_sel_d   = grant_src_s;
      if (acc_last_s) begin
        state_d = ST_IDLE;
        prio_d  = ~grant_src_s;
      end else begin
        state_d = lock_state(grant_src_s);
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      case (state_q)
        ST_LOCK_A, ST_LOCK_B: begin
          // Stall or silent source both burn the lock budget
          if (cnt_q == CNT_MAX) begin
            state_d = ST_IDLE;
            prio_d  = (state_q == ST_LOCK_A) ? SRC_B : SRC_A;
            err_d   = 1'b1;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= SRC_A;
      cnt_q       <= {CW{1'b0}};
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_sel     = out_sel_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_rr_stream_mux2.sv
// Self-checking bench for rr_stream_mux2: directed scenarios followed by a
// randomized phase, all checked against a packet-level reference model.
module tb_rr_stream_mux2;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_last, b_valid, b_last;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready;
  logic             out_valid, out_ready, out_last, out_sel, err_timeout;
  logic [WIDTH-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the link, whose turn it is, idle edges in a packet
  int               m_owner = -1;
  int               m_prio  = 0;
  int               m_idle  = 0;
  logic             m_ov = 1'b0, m_ol = 1'b0, m_os = 1'b0, m_err = 1'b0;
  logic [WIDTH-1:0] m_od = 8'h00;
  logic             took_a, took_b;

  rr_stream_mux2 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after
  task automatic step();
    logic can, gv, g, ea, eb, acc;
    #1;
    can = !rst && (!m_ov || out_ready);
    gv = 1'b1;
    g  = 1'b0;
    if (m_owner >= 0)              g = m_owner[0];
    else if (a_valid && b_valid)   g = m_prio[0];
    else if (a_valid)              g = 1'b0;
    else if (b_valid)              g = 1'b1;
    else                           gv = 1'b0;
    ea = can && gv && !g;
    eb = can && gv && g;
    check("a_ready", {31'd0, a_ready}, {31'd0, ea});
    check("b_ready", {31'd0, b_ready}, {31'd0, eb});
    took_a = ea && a_valid;
    took_b = eb && b_valid;
    acc = took_a || took_b;
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_prio = 0; m_idle = 0;
      m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_os = 1'b0; m_err = 1'b0;
    end else if (acc) begin
      m_ov = 1'b1; m_os = g; m_err = 1'b0; m_idle = 0;
      m_od = g ? b_data : a_data;
      m_ol = g ? b_last : a_last;
      if (m_ol) begin
        m_owner = -1;
        m_prio  = 1 - int'(g);
      end else begin
        m_owner = int'(g);
      end
    end else begin
      m_err = 1'b0;
      if (out_ready) m_ov = 1'b0;
      if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_prio  = 1 - m_owner;
          m_owner = -1;
          m_err   = 1'b1;
          m_idle  = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("out_data", {24'd0, out_data}, {24'd0, m_od});
    check("out_last", {31'd0, out_last}, {31'd0, m_ol});
    check("out_sel", {31'd0, out_sel}, {31'd0, m_os});
    check("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
  endtask

  initial begin
    logic [7:0] seen_d [4];
    logic       seen_s [4];
    logic [7:0] held;
    int         pulse_at;
    logic       b_after;

    // 1: reset with both sources valid
    rst = 1'b1; out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_grant_a", {30'd0, a_ready, b_ready}, 32'd2);

    // 2: alternating single beats at full rate
    for (int i = 0; i < 4; i++) begin
      step();
      seen_d[i] = out_data;
      seen_s[i] = out_sel;
    end
    check("rr_data0", {24'd0, seen_d[0]}, 32'h11);
    check("rr_data1", {24'd0, seen_d[1]}, 32'h22);
    check("rr_data2", {24'd0, seen_d[2]}, 32'h11);
    check("rr_data3", {24'd0, seen_d[3]}, 32'h22);
    check("rr_sel", {28'd0, seen_s[0], seen_s[1], seen_s[2], seen_s[3]}, 32'h5);

    // 3: multi-beat A packet while B waits
    b_data = 8'hB0; b_last = 1'b1;
    a_data = 8'hA0; a_last = 1'b0; step();
    check("pkt_beat0", {24'd0, out_data}, 32'hA0);
    a_data = 8'hA1; step();
    check("pkt_beat1", {24'd0, out_data}, 32'hA1);
    a_data = 8'hA2; a_last = 1'b1; step();
    check("pkt_beat2_last", {23'd0, out_last, out_data}, 32'h1A2);
    a_valid = 1'b0; step();
    check("pkt_then_b", {23'd0, out_sel, out_data}, 32'h1B0);

    // 4: output backpressure with a beat held
    b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h33; a_last = 1'b1;
    step();
    held = out_data;
    out_ready = 1'b0;
    b_valid = 1'b1; b_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
    end
    out_ready = 1'b1;
    step(); step();
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step();

    // 5: watchdog release of a stalled A packet
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b0;
    step();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h5B; b_last = 1'b1;
    pulse_at = -1; b_after = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (err_timeout && pulse_at < 0) pulse_at = i;
      if (i == 17) b_after = took_b;
    end
    check("timeout_cycle", pulse_at, 32'd16);
    check("b_after_timeout", {31'd0, b_after}, 32'd1);

    // 6: reset in the middle of a B packet
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h60; b_last = 1'b0;
    step();
    b_data = 8'h61; step();
    rst = 1'b1; step();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; a_valid = 1'b1; a_data = 8'h70; a_last = 1'b1;
    step();
    check("after_rst_a", {23'd0, out_sel, out_data}, 32'h070);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Randomized traffic; sources hold a beat until it is taken
    took_a = 1'b1; took_b = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int pv;
      pv = (i >= 250 && i < 350) ? 8 : 60;
      if (!a_valid || took_a) begin
        a_valid = ($urandom_range(0, 99) < pv);
        a_data  = 8'($urandom);
        a_last  = ($urandom_range(0, 3) == 0);
      end
      if (!b_valid || took_b) begin
        b_valid = ($urandom_range(0, 99) < pv);
        b_data  = 8'($urandom);
        b_last  = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
